// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Stage bit map: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    TRAP_DRAIN = 2'd2
  } state_e;

  typedef logic [4:0] HoldEnable;

  localparam int unsigned PC_BIT    = 0;
  localparam int unsigned IFID_BIT  = 1;
  localparam int unsigned IDEX_BIT  = 2;
  localparam int unsigned EXMEM_BIT = 3;
  localparam int unsigned MEMWB_BIT = 4;

  localparam HoldEnable HOLD_NONE = 5'b00000;
  localparam HoldEnable HOLD_IF   = 5'b00001 << PC_BIT;
  localparam HoldEnable HOLD_ID   = HOLD_IF | (5'b00001 << IFID_BIT);
  localparam HoldEnable HOLD_EX   = HOLD_ID | (5'b00001 << IDEX_BIT);
  localparam HoldEnable HOLD_MEM  = HOLD_EX | (5'b00001 << EXMEM_BIT);

  localparam logic [4:0] BUBBLE_IF  = 5'b00001 << IFID_BIT;
  localparam logic [4:0] BUBBLE_ID  = 5'b00001 << IDEX_BIT;
  localparam logic [4:0] BUBBLE_EX  = 5'b00001 << EXMEM_BIT;
  localparam logic [4:0] BUBBLE_MEM = 5'b00001 << MEMWB_BIT;

  localparam logic [4:0] BUBBLE_FLUSH_FE  = 5'b00110;
  localparam logic [4:0] BUBBLE_FLUSH_ALL = 5'b01110;

  typedef struct packed {
    HoldEnable  hold;
    logic [4:0] bubble;
  } stall_t;

  // Deepest requesting stage wins: it freezes itself and everything upstream.
  function automatic stall_t stall_pat(
    input logic if_s,
    input logic id_s,
    input logic ex_s,
    input logic mem_s
  );
    stall_t p;
    p = '{hold: HOLD_NONE, bubble: 5'b00000};
    priority case (1'b1)
      mem_s:   p = '{hold: HOLD_MEM, bubble: BUBBLE_MEM};
      ex_s:    p = '{hold: HOLD_EX,  bubble: BUBBLE_EX};
      id_s:    p = '{hold: HOLD_ID,  bubble: BUBBLE_ID};
      if_s:    p = '{hold: HOLD_IF,  bubble: BUBBLE_IF};
      default: p = '{hold: HOLD_NONE, bubble: 5'b00000};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Mispredict and stall-cycle counters for the sequencer.
// Both wrap silently at 2^CNT_W.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mis_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Count one per flagged cycle; reset clears both.
  always_ff @(posedge clk) begin
    if (rstn) begin
      mispred_cnt_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (mis_i)   mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      if (stall_i) stall_cnt_o   <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls, mispredict redirects, trap/mret redirects.
// A redirect is held until the fetch bus accepts it.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       CNT_W  = 32,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_stall_req_i,
  input  logic              id_stall_req_i,
  input  logic              ex_stall_req_i,
  input  logic              mem_stall_req_i,
  input  logic              if_ready_i,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_jump_en_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              ex_prd_taken_i,
  input  logic [ADDR_W-1:0] ex_prd_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              mret_req_i,
  input  logic [ADDR_W-1:0] mepc_i,
  output logic [4:0]        hold_en_o,
  output logic [4:0]        bubble_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              prd_fail,
  output logic [CNT_W-1:0]  mispred_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              full_q, full_d;

  logic              mis;
  logic              ex_busy;
  logic              xret;
  logic [ADDR_W-1:0] mis_tgt;
  logic [ADDR_W-1:0] xret_tgt;
  stall_t            sp;

  assign mis = ex_valid_i &
               ((ex_jump_en_i != ex_prd_taken_i) |
                (ex_jump_en_i & ex_prd_taken_i &
                 (ex_jump_addr_i != ex_prd_addr_i)));

  assign mis_tgt  = ex_jump_en_i ? ex_jump_addr_i
                                 : ex_pc_i + ADDR_W'(4);
  assign ex_busy  = mem_stall_req_i | ex_stall_req_i;
  assign xret     = trap_req_i | mret_req_i;
  assign xret_tgt = trap_req_i ? trap_vec_i : mepc_i;
  assign sp       = stall_pat(if_stall_req_i, id_stall_req_i,
                              ex_stall_req_i, mem_stall_req_i);

  // Next state, latched target and all per-cycle control outputs.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    full_d    = full_q;
    hold_en_o = HOLD_NONE;
    bubble_o  = 5'b00000;
    flush_o   = 1'b0;
    new_pc_o  = tgt_q;
    prd_fail  = 1'b0;
    if (rstn) begin
      state_d  = RUN;
      tgt_d    = RST_PC;
      full_d   = 1'b0;
      new_pc_o = RST_PC;
    end else begin
      unique case (state_q)
        RUN: begin
          if (xret) begin
            tgt_d  = xret_tgt;
            full_d = 1'b1;
            if (mem_stall_req_i) begin
              hold_en_o = HOLD_MEM;
              bubble_o  = BUBBLE_MEM;
              state_d   = TRAP_DRAIN;
            end else begin
              flush_o  = 1'b1;
              new_pc_o = xret_tgt;
              bubble_o = BUBBLE_FLUSH_ALL;
              if (!if_ready_i) state_d = REDIR_WAIT;
            end
          end else if (mis && !ex_busy) begin
            tgt_d    = mis_tgt;
            full_d   = 1'b0;
            prd_fail = 1'b1;
            flush_o  = 1'b1;
            new_pc_o = mis_tgt;
            bubble_o = BUBBLE_FLUSH_FE;
            if (!if_ready_i) state_d = REDIR_WAIT;
          end else begin
            hold_en_o = sp.hold;
            bubble_o  = sp.bubble;
          end
        end
        REDIR_WAIT: begin
          flush_o  = 1'b1;
          bubble_o = full_q ? BUBBLE_FLUSH_ALL : BUBBLE_FLUSH_FE;
          if (if_ready_i) state_d = RUN;
        end
        TRAP_DRAIN: begin
          if (mem_stall_req_i) begin
            hold_en_o = HOLD_MEM;
            bubble_o  = BUBBLE_MEM;
          end else begin
            flush_o  = 1'b1;
            bubble_o = BUBBLE_FLUSH_ALL;
            state_d  = if_ready_i ? RUN : REDIR_WAIT;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Sequencer state and pending redirect registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= RUN;
      tgt_q   <= RST_PC;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      full_q  <= full_d;
    end
  end

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rstn          (rstn),
    .mis_i         (prd_fail),
    .stall_i       (|hold_en_o),
    .mispred_cnt_o (mispred_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic
// checked against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] RPC = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_s, id_s, ex_s, mem_s, rdy;
  logic          exv, jen, ptk, trap, mret;
  logic [AW-1:0] pc, ja, pa, vec, mepc;
  logic [4:0]    hold, bub;
  logic          flush, prd;
  logic [AW-1:0] npc;
  logic [CW-1:0] mcnt, scnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .CNT_W(CW), .RST_PC(RPC)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .if_stall_req_i  (if_s),
    .id_stall_req_i  (id_s),
    .ex_stall_req_i  (ex_s),
    .mem_stall_req_i (mem_s),
    .if_ready_i      (rdy),
    .ex_valid_i      (exv),
    .ex_pc_i         (pc),
    .ex_jump_en_i    (jen),
    .ex_jump_addr_i  (ja),
    .ex_prd_taken_i  (ptk),
    .ex_prd_addr_i   (pa),
    .trap_req_i      (trap),
    .trap_vec_i      (vec),
    .mret_req_i      (mret),
    .mepc_i          (mepc),
    .hold_en_o       (hold),
    .bubble_o        (bub),
    .flush_o         (flush),
    .new_pc_o        (npc),
    .prd_fail        (prd),
    .mispred_cnt_o   (mcnt),
    .stall_cnt_o     (scnt)
  );

  typedef struct {
    logic          rst, ifs, ids, exs, mems, rdy;
    logic          exv, jen, ptk, trap, mret;
    logic [AW-1:0] pc, ja, pa, vec, mepc;
  } stim_t;

  typedef struct {
    logic [4:0]    hold, bub;
    logic          flush, prd;
    logic [AW-1:0] npc;
    logic [CW-1:0] mc, sc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: a redirect may be waiting on fetch or on the memory drain.
  logic          m_wait  = 1'b0;
  logic          m_drain = 1'b0;
  logic          m_full  = 1'b0;
  logic [AW-1:0] m_tgt   = RPC;
  logic [CW-1:0] m_mc    = '0;
  logic [CW-1:0] m_sc    = '0;

  task automatic model(input stim_t s, output exp_t e);
    logic mis, iss;
    int   k;
    e.mc = m_mc; e.sc = m_sc;
    e.hold = '0; e.bub = '0; e.flush = 1'b0; e.prd = 1'b0;
    e.npc = m_tgt;
    if (s.rst) begin
      e.npc = RPC;
      m_wait = 1'b0; m_drain = 1'b0; m_full = 1'b0;
      m_tgt = RPC; m_mc = '0; m_sc = '0;
      return;
    end
    mis = s.exv && ((s.jen != s.ptk) ||
                    (s.jen && s.ptk && s.ja != s.pa));
    k = s.mems ? 4 : s.exs ? 3 : s.ids ? 2 : s.ifs ? 1 : 0;
    iss = 1'b0;
    if (m_wait) begin
      e.flush = 1'b1;
      e.bub = m_full ? 5'd14 : 5'd6;
      if (s.rdy) m_wait = 1'b0;
    end else if (m_drain) begin
      if (s.mems) k = 4;
      else begin m_drain = 1'b0; iss = 1'b1; end
      if (iss) k = 0;
    end else if (s.trap || s.mret) begin
      m_tgt = s.trap ? s.vec : s.mepc;
      m_full = 1'b1;
      if (s.mems) begin m_drain = 1'b1; k = 4; end
      else begin iss = 1'b1; k = 0; end
    end else if (mis && !s.mems && !s.exs) begin
      m_tgt = s.jen ? s.ja : s.pc + 32'd4;
      m_full = 1'b0;
      e.prd = 1'b1;
      iss = 1'b1;
      k = 0;
    end
    if (m_wait && !iss) k = 0;
    if (iss) begin
      e.flush = 1'b1;
      e.npc = m_tgt;
      e.bub = m_full ? 5'd14 : 5'd6;
      if (!s.rdy) m_wait = 1'b1;
    end else if (k > 0 && !e.flush) begin
      e.hold = 5'((1 << k) - 1);
      e.bub  = 5'(1 << k);
    end
    m_mc = m_mc + CW'(e.prd);
    m_sc = m_sc + CW'(e.hold != 5'd0);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, ifs: 1'b0, ids: 1'b0, exs: 1'b0, mems: 1'b0,
          rdy: 1'b1, exv: 1'b0, jen: 1'b0, ptk: 1'b0, trap: 1'b0,
          mret: 1'b0, pc: '0, ja: '0, pa: '0, vec: '0, mepc: '0};
    return s;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    case ($urandom_range(3))
      0:       a = 32'h0000_0100;
      1:       a = 32'h0000_0200;
      2:       a = 32'hFFFF_FFFC;
      default: a = $urandom() & 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  task automatic apply(input stim_t s, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = s.rst; if_s = s.ifs; id_s = s.ids; ex_s = s.exs;
    mem_s = s.mems; rdy = s.rdy; exv = s.exv; jen = s.jen;
    ptk = s.ptk; trap = s.trap; mret = s.mret; pc = s.pc;
    ja = s.ja; pa = s.pa; vec = s.vec; mepc = s.mepc;
    model(s, e);
    if (chk) sbq.push_back(e);
  endtask

  task automatic check(input string nm, input logic [AW-1:0] act,
                       input logic [AW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("hold_en",     AW'(hold),  AW'(e.hold));
      check("bubble",      AW'(bub),   AW'(e.bub));
      check("flush",       AW'(flush), AW'(e.flush));
      check("prd_fail",    AW'(prd),   AW'(e.prd));
      check("new_pc",      npc,        e.npc);
      check("mispred_cnt", AW'(mcnt),  AW'(e.mc));
      check("stall_cnt",   AW'(scnt),  AW'(e.sc));
    end
  end

  initial begin
    stim_t s;
    rstn = 1'b1; if_s = 0; id_s = 0; ex_s = 0; mem_s = 0; rdy = 1;
    exv = 0; jen = 0; ptk = 0; trap = 0; mret = 0;
    pc = '0; ja = '0; pa = '0; vec = '0; mepc = '0;

    s = idle(); s.rst = 1'b1;
    apply(s, 0);
    apply(s, 1);
    apply(idle(), 1);

    s = idle(); s.ids = 1'b1;
    repeat (3) apply(s, 1);

    s = idle(); s.exv = 1; s.jen = 1; s.ja = 32'h100;
    apply(s, 1);
    apply(idle(), 1);

    s = idle(); s.exv = 1; s.ptk = 1; s.pa = 32'h200;
    s.pc = 32'h40; s.rdy = 0;
    repeat (3) apply(s, 1);
    s.rdy = 1;
    apply(s, 1);
    apply(idle(), 1);

    s = idle(); s.exv = 1; s.jen = 1; s.ja = 32'h300; s.mems = 1;
    repeat (2) apply(s, 1);
    s.mems = 0;
    apply(s, 1);
    apply(idle(), 1);

    s = idle(); s.trap = 1; s.vec = 32'h80; s.mems = 1;
    s.exv = 1; s.jen = 1; s.ja = 32'h500;
    repeat (2) apply(s, 1);
    s.mems = 0; s.trap = 0;
    apply(s, 1);
    apply(idle(), 1);

    s = idle(); s.exv = 1; s.jen = 1; s.ja = 32'h600; s.rdy = 0;
    apply(s, 1);
    s.rst = 1;
    apply(s, 1);
    apply(idle(), 1);
    apply(idle(), 1);

    s = idle(); s.exv = 1; s.pc = 32'hFFFF_FFFC; s.ptk = 1;
    s.pa = 32'h10;
    apply(s, 1);
    s = idle(); s.mret = 1; s.mepc = 32'h1234; s.rdy = 0;
    apply(s, 1);
    s = idle(); s.rdy = 0;
    apply(s, 1);
    apply(idle(), 1);

    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(79) == 0);
      s.ifs  = ($urandom_range(3) == 0);
      s.ids  = ($urandom_range(3) == 0);
      s.exs  = ($urandom_range(4) == 0);
      s.mems = ($urandom_range(3) == 0);
      s.rdy  = ($urandom_range(3) != 0);
      s.exv  = 1'($urandom_range(1));
      s.jen  = 1'($urandom_range(1));
      s.ptk  = 1'($urandom_range(1));
      s.trap = ($urandom_range(15) == 0);
      s.mret = ($urandom_range(15) == 0);
      s.pc   = pick_addr();
      s.ja   = pick_addr();
      s.pa   = $urandom_range(1) ? s.ja : pick_addr();
      s.vec  = pick_addr();
      s.mepc = pick_addr();
      apply(s, 1);
    end

    apply(idle(), 1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", AW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
